// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the core load/store path, the debug/loader port and the data memory.
// The arbiter takes the slave view; the core, debug host and memory together form the master.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic              dbg_halt_req;
    logic              dbg_halted;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_halt_req,
        output dbg_ready, dbg_rdata, dbg_rvalid, dbg_halted,
        output mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_halt_req,
        input  dbg_ready, dbg_rdata, dbg_rvalid, dbg_halted,
        input  mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority, the debug port is starvation-protected
// and can halt the core for exclusive access.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic              halted;
    logic              grant_dbg;
    logic              grant_core;
    logic              stall;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              write_mux;

    assign halted = (state == HALTED);

    // Grants are masked during reset so no memory write or debug accept can leak out.
    always_comb begin
        grant_dbg  = 1'b0;
        grant_core = 1'b0;
        if (!rst) begin
            grant_dbg  = bus.dbg_valid & (halted | ~bus.core_req | (wait_cnt == WAIT_LIMIT));
            grant_core = bus.core_req & ~halted & ~grant_dbg;
        end
        stall = ~rst & (halted | (bus.core_req & grant_dbg));
    end

    always_comb begin
        addr_mux  = bus.core_addr;
        wdata_mux = bus.core_wdata;
        write_mux = 1'b0;
        if (grant_dbg) begin
            addr_mux  = bus.dbg_addr;
            wdata_mux = bus.dbg_wdata;
            write_mux = bus.dbg_we;
        end else if (grant_core) begin
            write_mux = bus.core_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN:     if (bus.dbg_halt_req)  state <= HALTED;
                HALTED:  if (!bus.dbg_halt_req) state <= RUN;
                default: state <= RUN;
            endcase

            if (!bus.dbg_valid || grant_dbg) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (grant_dbg && !bus.dbg_we) begin
                rdata_q  <= bus.mem_rdata;
                rvalid_q <= 1'b1;
            end else begin
                rvalid_q <= 1'b0;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.core_rdata = bus.mem_rdata;
    assign bus.core_stall = stall;
    assign bus.dbg_ready  = grant_dbg;
    assign bus.dbg_rdata  = rdata_q;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_halted = halted;
    assign bus.mem_write  = write_mux;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wdata  = wdata_mux;
endmodule
